mem_arbiter: RTL and testbench

Shares one data-memory port between NUM_REQ requesters: the per-stage matchers and the table-update path. Each requester drives a matcher-style port: it holds ce across a multi-beat burst, and each cycle with ready completes one beat. The arbiter locks a grant for the whole burst and rotates fairly between bursts. It sits between the processor stages and the single memory controller.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/def.svh | 14 +
 rtl/rr_picker.sv | 34 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: arbiter state type, bus widths and the rotate-pointer helper.
`include "def.svh"

package mem_arbiter_pkg;

   localparam int unsigned ADDR_W          = 32;
   localparam int unsigned DATA_W          = 32;
   localparam int unsigned NUM_REQ_DEFAULT = `MEM_ARB_NUM_REQ;

   typedef enum logic {
      StIdle,
      StBusy
   } arb_state_e;

   // Index after idx, wrapping at n back to 0.
   function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/def.svh
// def.svh: system-wide bus widths and constants shared across the processor.
`ifndef DEF_SVH
`define DEF_SVH

`define TRUE     1'b1
`define FALSE    1'b0
`define ZERO     32'h0000_0000
`define ADDR_BUS 31:0
`define DATA_BUS 31:0

// Requesters sharing the single data-memory port.
`define MEM_ARB_NUM_REQ 4

`endif

// File: rtl/rr_picker.sv
// rr_picker: combinational search for the first set request bit, starting at rr_ptr with wrap.
// Fixed-priority users tie rr_ptr_i to zero.
module rr_picker #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic [IDX_W-1:0]   winner_o,
   output logic               any_req_o
);

   localparam int unsigned SUM_W = IDX_W + 1;

   // One extra bit holds the unwrapped rr_ptr + offset.
   logic [SUM_W-1:0] idx;

   always_comb begin
      winner_o  = '0;
      any_req_o = 1'b0;
      idx       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, rr_ptr_i} + SUM_W'(i);
         if (idx >= SUM_W'(NUM_REQ)) begin
            idx = idx - SUM_W'(NUM_REQ);
         end
         if (!any_req_o && req_i[idx[IDX_W-1:0]]) begin
            any_req_o = 1'b1;
            winner_o  = idx[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory port between NUM_REQ burst requesters, locking the grant
// per burst. Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
`include "def.svh"

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_ce_i,
   input  logic [NUM_REQ-1:0]            req_we_i,
   input  logic [NUM_REQ-1:0][`ADDR_BUS] req_addr_i,
   input  logic [NUM_REQ-1:0][3:0]       req_width_i,
   input  logic [NUM_REQ-1:0][`DATA_BUS] req_data_i,
   output logic [`DATA_BUS]              req_data_o,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          mem_ce_o,
   output logic                          mem_we_o,
   output logic [`ADDR_BUS]              mem_addr_o,
   output logic [3:0]                    mem_width_o,
   output logic [`DATA_BUS]              mem_data_o,
   input  logic [`DATA_BUS]              mem_data_i,
   input  logic                          mem_ready_i,
   output logic                          grant_valid_o,
   output logic [IDX_W-1:0]              grant_o
);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] pick_ptr;
   logic [IDX_W-1:0] winner;
   logic             any_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign pick_ptr = '0;
`else
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   assign pick_ptr = rr_ptr_q;
`endif

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i     (req_ce_i),
      .rr_ptr_i  (pick_ptr),
      .winner_o  (winner),
      .any_req_o (any_req)
   );

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_d = rr_ptr_q;
`endif
      case (state_q)
         StIdle: begin
            if (any_req) begin
               grant_d  = winner;
               state_d  = StBusy;
`ifndef MEM_ARB_FIXED_PRIO_EN
               // The new owner drops to lowest priority for the next round.
               rr_ptr_d = IDX_W'(next_idx(32'(winner), NUM_REQ));
`endif
            end
         end
         StBusy: begin
            if (!req_ce_i[grant_q]) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         grant_q  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   // Memory side is a pure mux of the owner; ce drops in the same cycle the owner releases.
   always_comb begin
      mem_ce_o    = `FALSE;
      mem_we_o    = `FALSE;
      mem_addr_o  = `ZERO;
      mem_width_o = '0;
      mem_data_o  = `ZERO;
      req_ready_o = '0;
      if (state_q == StBusy) begin
         mem_ce_o             = req_ce_i[grant_q];
         mem_we_o             = req_we_i[grant_q];
         mem_addr_o           = req_addr_i[grant_q];
         mem_width_o          = req_width_i[grant_q];
         mem_data_o           = req_data_i[grant_q];
         req_ready_o[grant_q] = mem_ready_i;
      end
   end

   assign req_data_o    = mem_data_i;
   assign grant_valid_o = (state_q == StBusy);
   assign grant_o       = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with NUM_REQ=4.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int unsigned N = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N-1:0]           req_ce;
   logic [N-1:0]           req_we;
   logic [N-1:0][ADDR_W-1:0] req_addr;
   logic [N-1:0][3:0]      req_width;
   logic [N-1:0][DATA_W-1:0] req_data;
   logic [DATA_W-1:0]      rdata_bcast;
   logic [N-1:0]           req_ready;
   logic                   mem_ce;
   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_addr;
   logic [3:0]             mem_width;
   logic [DATA_W-1:0]      mem_wdata;
   logic [DATA_W-1:0]      mem_rdata;
   logic                   mem_ready;
   logic                   grant_valid;
   logic [1:0]             grant;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .NUM_REQ (N)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_ce_i      (req_ce),
      .req_we_i      (req_we),
      .req_addr_i    (req_addr),
      .req_width_i   (req_width),
      .req_data_i    (req_data),
      .req_data_o    (rdata_bcast),
      .req_ready_o   (req_ready),
      .mem_ce_o      (mem_ce),
      .mem_we_o      (mem_we),
      .mem_addr_o    (mem_addr),
      .mem_width_o   (mem_width),
      .mem_data_o    (mem_wdata),
      .mem_data_i    (mem_rdata),
      .mem_ready_i   (mem_ready),
      .grant_valid_o (grant_valid),
      .grant_o       (grant)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      req_ce = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_ce    = '0;
      req_we    = 4'b1111;
      req_width = {4{4'hF}};
      mem_ready = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      step();
      step();
      sample();
      total++;
      if ({grant_valid, grant, mem_ce, mem_we, req_ready} !== 8'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b expected %b",
                  {grant_valid, grant, mem_ce, mem_we, req_ready}, 8'b0);
      end
      total++;
      if ({mem_addr, mem_width, mem_wdata} !== 68'h0) begin
         bad++;
         $display("FAIL reset_bus: got %h expected 0", {mem_addr, mem_width, mem_wdata});
      end
      total++;
      if (rdata_bcast !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL reset_rdata: got %h expected deadbeef", rdata_bcast);
      end
      rst = 1'b0;
      step();
      sample();
      total++;
      if ({grant_valid, mem_ce} !== 2'b00) begin
         bad++;
         $display("FAIL idle_no_req: got %b expected 00", {grant_valid, mem_ce});
      end
      step();
      mem_ready = 1'b0;
   endtask

   task automatic test_single();
      req_we       = '0;
      req_width    = '0;
      req_width[2] = 4'hF;
      mem_ready    = 1'b1;
      req_addr[2]  = 32'h100;
      req_ce       = 4'b0100;
      sample();
      total++;
      if ({grant_valid, mem_ce} !== 2'b00) begin
         bad++;
         $display("FAIL single_latency: got %b expected 00", {grant_valid, mem_ce});
      end
      step();
      for (int b = 0; b < 3; b++) begin
         req_addr[2] = 32'(32'h100 + 4 * b);
         req_data[2] = 32'(32'h1234_5678 + b);
         sample();
         total++;
         if ({grant_valid, grant, mem_ce, req_ready} !== {1'b1, 2'd2, 1'b1, 4'b0100}) begin
            bad++;
            $display("FAIL single_beat%0d: got %b expected %b", b,
                     {grant_valid, grant, mem_ce, req_ready}, {1'b1, 2'd2, 1'b1, 4'b0100});
         end
         total++;
         if ({mem_addr, mem_width, mem_wdata} !==
             {32'(32'h100 + 4 * b), 4'hF, 32'(32'h1234_5678 + b)}) begin
            bad++;
            $display("FAIL single_bus%0d: got %h expected %h", b,
                     {mem_addr, mem_width, mem_wdata},
                     {32'(32'h100 + 4 * b), 4'hF, 32'(32'h1234_5678 + b)});
         end
         step();
      end
      req_ce    = '0;
      mem_ready = 1'b0;
      sample();
      total++;
      if ({grant_valid, mem_ce} !== 2'b10) begin
         bad++;
         $display("FAIL single_release: got %b expected 10", {grant_valid, mem_ce});
      end
      step();
      sample();
      total++;
      if ({grant_valid, mem_ce} !== 2'b00) begin
         bad++;
         $display("FAIL single_idle: got %b expected 00", {grant_valid, mem_ce});
      end
      step();
   endtask

   task automatic test_round_robin();
      do_reset();
      mem_ready = 1'b1;
      req_ce    = 4'b1111;
      sample();
      total++;
      if (grant_valid !== 1'b0) begin
         bad++;
         $display("FAIL rr_first_idle: got %b expected 0", grant_valid);
      end
      step();
      for (int r = 0; r < 5; r++) begin
         logic [1:0] g;
         g = 2'(r % 4);
         for (int b = 0; b < 2; b++) begin
            sample();
            total++;
            if ({grant_valid, grant, req_ready} !== {1'b1, g, 4'b0001 << g}) begin
               bad++;
               $display("FAIL rr_round%0d_beat%0d: got %b expected %b", r, b,
                        {grant_valid, grant, req_ready}, {1'b1, g, 4'b0001 << g});
            end
            step();
         end
         req_ce[g] = 1'b0;
         sample();
         total++;
         if ({grant_valid, mem_ce} !== 2'b10) begin
            bad++;
            $display("FAIL rr_release%0d: got %b expected 10", r, {grant_valid, mem_ce});
         end
         step();
         // Releaser re-asserts in the dead cycle and must still lose.
         req_ce = (r == 4) ? 4'b0000 : 4'b1111;
         sample();
         total++;
         if ({grant_valid, mem_ce} !== 2'b00) begin
            bad++;
            $display("FAIL rr_dead%0d: got %b expected 00", r, {grant_valid, mem_ce});
         end
         step();
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_lock();
      do_reset();
      mem_ready = 1'b1;
      req_ce    = 4'b0010;
      step();
      sample();
      total++;
      if ({grant_valid, grant} !== {1'b1, 2'd1}) begin
         bad++;
         $display("FAIL lock_grant1: got %b expected 101", {grant_valid, grant});
      end
      step();
      req_ce = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         sample();
         total++;
         if ({grant_valid, grant, req_ready} !== {1'b1, 2'd1, 4'b0010}) begin
            bad++;
            $display("FAIL lock_hold%0d: got %b expected %b", i,
                     {grant_valid, grant, req_ready}, {1'b1, 2'd1, 4'b0010});
         end
         step();
      end
      req_ce = 4'b0001;
      sample();
      total++;
      if ({grant_valid, mem_ce, req_ready[0]} !== 3'b100) begin
         bad++;
         $display("FAIL lock_release: got %b expected 100", {grant_valid, mem_ce, req_ready[0]});
      end
      step();
      sample();
      total++;
      if ({grant_valid, req_ready} !== 5'b0) begin
         bad++;
         $display("FAIL lock_dead: got %b expected 00000", {grant_valid, req_ready});
      end
      step();
      sample();
      total++;
      if ({grant_valid, grant, req_ready} !== {1'b1, 2'd0, 4'b0001}) begin
         bad++;
         $display("FAIL lock_req0: got %b expected %b",
                  {grant_valid, grant, req_ready}, {1'b1, 2'd0, 4'b0001});
      end
      step();
      req_ce    = '0;
      mem_ready = 1'b0;
      step();
      step();
   endtask

   task automatic test_slow_mem();
      req_we      = '0;
      req_addr[3] = 32'h200;
      req_ce      = 4'b1000;
      mem_ready   = 1'b0;
      step();
      for (int c = 0; c < 12; c++) begin
         mem_ready = (c % 3 == 2);
         mem_rdata = 32'(32'hA000_0000 + c);
         sample();
         total++;
         if ({grant_valid, grant, mem_ce, mem_we, req_ready} !==
             {1'b1, 2'd3, 1'b1, 1'b0, ((c % 3 == 2) ? 4'b1000 : 4'b0000)}) begin
            bad++;
            $display("FAIL slow_ctrl%0d: got %b expected %b", c,
                     {grant_valid, grant, mem_ce, mem_we, req_ready},
                     {1'b1, 2'd3, 1'b1, 1'b0, ((c % 3 == 2) ? 4'b1000 : 4'b0000)});
         end
         total++;
         if (rdata_bcast !== 32'(32'hA000_0000 + c)) begin
            bad++;
            $display("FAIL slow_rdata%0d: got %h expected %h", c, rdata_bcast,
                     32'(32'hA000_0000 + c));
         end
         step();
      end
      req_ce    = '0;
      mem_ready = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req_ce = 4'b0100;
      step();
      req_ce = 4'b1110;
      sample();
      total++;
      if ({grant_valid, grant} !== {1'b1, 2'd2}) begin
         bad++;
         $display("FAIL rst_pre: got %b expected 110", {grant_valid, grant});
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      sample();
      total++;
      if ({grant_valid, mem_ce, grant} !== 4'b0000) begin
         bad++;
         $display("FAIL rst_abort: got %b expected 0000", {grant_valid, mem_ce, grant});
      end
      step();
      sample();
      total++;
      if ({grant_valid, grant} !== {1'b1, 2'd1}) begin
         bad++;
         $display("FAIL rst_lowest: got %b expected 101", {grant_valid, grant});
      end
      step();
      req_ce = '0;
      step();
      step();
   endtask

`ifdef MEM_ARB_FIXED_PRIO_EN
   task automatic test_fixed_prio();
      do_reset();
      mem_ready = 1'b1;
      req_ce    = 4'b1010;
      step();
      for (int r = 0; r < 3; r++) begin
         sample();
         total++;
         if ({grant_valid, grant} !== {1'b1, 2'd1}) begin
            bad++;
            $display("FAIL fixed_win%0d: got %b expected 101", r, {grant_valid, grant});
         end
         req_ce = 4'b1000;
         step();
         req_ce = 4'b1010;
         sample();
         total++;
         if (grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL fixed_dead%0d: got %b expected 0", r, grant_valid);
         end
         step();
      end
      req_ce    = '0;
      mem_ready = 1'b0;
      step();
      step();
   endtask
`endif

   initial begin
      rst       = 1'b1;
      req_ce    = '0;
      req_we    = '0;
      req_width = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < int'(N); i++) begin
         req_addr[i] = 32'(32'hFFFF_0000 + i);
         req_data[i] = 32'(32'h5555_0000 + i);
      end
      test_reset();
      test_single();
      test_round_robin();
      test_lock();
      test_slow_mem();
      test_reset_mid_burst();
`ifdef MEM_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
